// File: rtl/pw_utmi_tx_pkg.sv
// pw_utmi_tx_pkg: shared FSM states, status codes, OpMode encodings and USB CRC16 constants/helper for the UTMI transmit engine
package pw_utmi_tx_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, GAP, SEND, DONE} state_t;
  typedef enum logic [1:0] {ST_OK = 2'b00, ST_ABORT = 2'b01, ST_TIMEOUT = 2'b10, ST_LOAD_ERR = 2'b11} status_t;
  localparam logic [1:0] OPM_NONDRIVE = 2'b01;
  localparam logic [1:0] OPM_NORMAL = 2'b00;
  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REF = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'hB001;
  // one byte of the reflected USB CRC16, data bits taken LSB first as they go on the wire
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? CRC16_POLY_REF : 16'h0000);
    return r;
  endfunction
endpackage

// File: rtl/pw_utmi_tx_if.sv
// pw_utmi_tx_if: load/start controls and UTMI transmit-side signals of the transmit engine
interface pw_utmi_tx_if #(parameter int pADDR_W = 6);
  logic [7:0] I_load_data;
  logic [pADDR_W-1:0] I_load_addr;
  logic I_load_wr;
  logic [pADDR_W:0] I_len;
  logic [7:0] I_gap;
  logic I_start;
  logic I_abort;
  logic fe_txrdy;
  logic [7:0] O_fe_data;
  logic O_fe_data_oe;
  logic O_txvalid;
  logic [1:0] O_opmode;
  logic O_busy;
  logic O_done;
  logic [1:0] O_status;
  logic O_load_err;
  modport master (
    output I_load_data, I_load_addr, I_load_wr, I_len, I_gap, I_start, I_abort, fe_txrdy,
    input O_fe_data, O_fe_data_oe, O_txvalid, O_opmode, O_busy, O_done, O_status, O_load_err
  );
  modport slave (
    input I_load_data, I_load_addr, I_load_wr, I_len, I_gap, I_start, I_abort, fe_txrdy,
    output O_fe_data, O_fe_data_oe, O_txvalid, O_opmode, O_busy, O_done, O_status, O_load_err
  );
endinterface

// File: rtl/pw_utmi_tx_crc16.sv
// pw_usb_crc16: byte-wide USB CRC16 next-state logic plus state register; only built with PW_TX_CRC16_EN
`ifdef PW_TX_CRC16_EN
module pw_usb_crc16
  import pw_utmi_tx_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic init,
  input logic en,
  input logic [7:0] din,
  output logic [15:0] crc,
  output logic [15:0] crc_nxt
);
  assign crc_nxt = init ? CRC16_INIT : en ? crc16_byte(crc, din) : crc;
  // running CRC over the accepted payload bytes
  always_ff @(posedge clk) crc <= rst ? CRC16_INIT : crc_nxt;
endmodule
`endif

// File: rtl/pw_utmi_tx.sv
// pw_utmi_tx: UTMI transmit engine sending a buffered packet over TxValid/TxReady; PW_TX_CRC16_EN appends a USB CRC16
module pw_utmi_tx #(
  parameter int pBUF_DEPTH = 64,
  parameter int pADDR_W = 6,
  parameter int pTXRDY_TIMEOUT = 1024
) (
  input logic fe_clk,
  input logic reset_i,
  pw_utmi_tx_if.slave bus
);
  import pw_utmi_tx_pkg::*;
  localparam int IW = pADDR_W + 2;
  localparam int TW = $clog2(pTXRDY_TIMEOUT + 1);
  localparam logic [pADDR_W:0] DEPTH = (pADDR_W + 1)'(pBUF_DEPTH);
  logic [7:0] mem [pBUF_DEPTH];
  state_t state, state_nxt;
  status_t fin;
  logic [pADDR_W:0] len_q;
  logic [7:0] gap_cnt;
  logic [IW-1:0] idx, nidx, total;
  logic [TW-1:0] to_cnt;
  logic [7:0] nbyte;
  logic start, accept, last, timeout, own;
  assign start = state == IDLE && bus.I_start;
  assign accept = state == SEND && bus.O_txvalid && bus.fe_txrdy;
  assign timeout = state == SEND && !bus.fe_txrdy && to_cnt == TW'(pTXRDY_TIMEOUT);
  assign nidx = idx + 1'b1;
  assign last = nidx == total;
`ifdef PW_TX_CRC16_EN
  logic [15:0] crc, crc_nxt;
  assign total = IW'(len_q) + IW'(2);
  assign nbyte = nidx < IW'(len_q) ? mem[nidx[pADDR_W-1:0]] : nidx == IW'(len_q) ? ~crc_nxt[7:0] : ~crc[15:8];
  pw_usb_crc16 u_crc (
    .clk(fe_clk),
    .rst(reset_i),
    .init(start),
    .en(accept && idx != '0 && idx < IW'(len_q)),
    .din(bus.O_fe_data),
    .crc(crc),
    .crc_nxt(crc_nxt)
  );
`else
  assign total = IW'(len_q);
  assign nbyte = mem[nidx[pADDR_W-1:0]];
`endif
  // buffer write port, locked out while a packet owns the buffer
  always_ff @(posedge fe_clk) if (bus.I_load_wr && !bus.O_busy) mem[bus.I_load_addr] <= bus.I_load_data;
  // state register
  always_ff @(posedge fe_clk) state <= reset_i ? IDLE : state_nxt;
  // next state, bus ownership and end-of-packet status
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = !bus.I_start ? IDLE : bus.I_len == '0 ? DONE : SETUP;
      SETUP: state_nxt = bus.I_abort ? DONE : gap_cnt == '0 ? SEND : GAP;
      GAP: state_nxt = bus.I_abort ? DONE : gap_cnt == 8'd1 ? SEND : GAP;
      SEND: state_nxt = bus.I_abort || timeout || (accept && last) ? DONE : SEND;
      default: state_nxt = IDLE;
    endcase
    own = state_nxt inside {SETUP, GAP, SEND} || (state_nxt == DONE && state != IDLE);
    fin = bus.I_abort ? ST_ABORT : timeout ? ST_TIMEOUT : (bus.O_load_err || bus.I_load_wr) ? ST_LOAD_ERR : ST_OK;
  end
  // registered outputs and datapath; the byte register doubles as the prefetched buffer read
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      bus.O_txvalid <= 1'b0;
      bus.O_fe_data_oe <= 1'b0;
      bus.O_fe_data <= '0;
      bus.O_opmode <= OPM_NONDRIVE;
      bus.O_busy <= 1'b0;
      bus.O_done <= 1'b0;
      bus.O_status <= ST_OK;
      bus.O_load_err <= 1'b0;
      len_q <= '0;
      gap_cnt <= '0;
      idx <= '0;
      to_cnt <= '0;
    end else begin
      bus.O_busy <= state_nxt != IDLE;
      bus.O_done <= state_nxt == DONE;
      bus.O_txvalid <= state_nxt == SEND;
      bus.O_opmode <= own ? OPM_NORMAL : OPM_NONDRIVE;
      bus.O_fe_data_oe <= own;
      if (start) begin
        len_q <= bus.I_len > DEPTH ? DEPTH : bus.I_len;
        gap_cnt <= bus.I_gap;
        bus.O_status <= ST_OK;
        bus.O_load_err <= 1'b0;
      end
      if (bus.I_load_wr && bus.O_busy) bus.O_load_err <= 1'b1;
      if (state == GAP) gap_cnt <= gap_cnt - 8'd1;
      if (state_nxt == DONE && state != IDLE) bus.O_status <= fin;
      if (state != SEND && state_nxt == SEND) begin
        idx <= '0;
        to_cnt <= '0;
        bus.O_fe_data <= mem[0];
      end else if (accept) begin
        idx <= nidx;
        to_cnt <= '0;
        bus.O_fe_data <= nbyte;
      end else if (state == SEND) to_cnt <= to_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pw_utmi_tx.sv
// tb_pw_utmi_tx: directed and randomized packets against a byte-list model of the transmit engine
module tb_pw_utmi_tx;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  logic [7:0] sh [64];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int rise, hi, done_k, hold_cnt;
  logic [1:0] st, opm_first, opm_after;
  logic busy_after, oe_after;
  bit opm_bad, stab_bad;
  always #5 clk = ~clk;
  pw_utmi_tx_if #(.pADDR_W(6)) bus();
  pw_utmi_tx #(.pBUF_DEPTH(64), .pADDR_W(6), .pTXRDY_TIMEOUT(16)) dut (
    .fe_clk(clk),
    .reset_i(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] c, r;
    logic [7:0] b;
    c = 16'hFFFF;
    for (int i = 1; i < n; i++) begin
      for (int j = 0; j < 8; j++) b[j] = sh[i][7-j];
      for (int j = 7; j >= 0; j--) c = {c[14:0], 1'b0} ^ ((c[15] ^ b[j]) ? 16'h8005 : 16'h0000);
    end
    for (int j = 0; j < 16; j++) r[j] = c[15-j];
    return ~r;
  endfunction

  task automatic build_exp(input int len);
    int n;
    logic [15:0] c;
    n = len > 64 ? 64 : len;
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(sh[i]);
`ifdef PW_TX_CRC16_EN
    if (n > 0) begin
      c = ref_crc(n);
      exp_q.push_back(c[7:0]);
      exp_q.push_back(c[15:8]);
    end
`else
    c = 16'h0;
`endif
  endtask

  function automatic int mism();
    int m = 0;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) if (got[i] !== exp_q[i]) m++;
    return m;
  endfunction

  task automatic load(input int a, input logic [7:0] d);
    bus.I_load_addr = 6'(a);
    bus.I_load_data = d;
    bus.I_load_wr = 1'b1;
    sh[a] = d;
    @(posedge clk); #1;
    bus.I_load_wr = 1'b0;
  endtask

  task automatic start_pkt(input int len, input int gap);
    bus.I_len = 7'(len);
    bus.I_gap = 8'(gap);
    bus.I_start = 1'b1;
    @(posedge clk); #1;
    bus.I_start = 1'b0;
  endtask

  // mode 0 ready always, 1 random ready, 2 ready stuck low, 3 ready low 3 cycles on byte 2
  task automatic run_tx(input int mode, input int abort_at, input logic [7:0] hold_byte);
    int low_used = 0;
    logic [7:0] prev_d = 8'h0;
    bit prev_hold = 0;
    bit rdy;
    got.delete();
    rise = -1; hi = 0; done_k = -1; hold_cnt = 0; opm_bad = 0; stab_bad = 0;
    opm_first = bus.O_opmode;
    for (int k = 0; k < 400; k++) begin
      if (bus.O_done) begin
        done_k = k;
        st = bus.O_status;
        break;
      end
      if (bus.O_txvalid) begin
        if (rise < 0) rise = k;
        hi++;
        if (bus.O_opmode !== 2'b00) opm_bad = 1;
        if (bus.O_fe_data === hold_byte) hold_cnt++;
        if (prev_hold && bus.O_fe_data !== prev_d) stab_bad = 1;
      end
      rdy = mode == 0 ? 1'b1 : mode == 1 ? ($urandom % 4 != 0) : mode == 2 ? 1'b0 : !(got.size() == 2 && low_used < 3);
      if (mode == 3 && !rdy && bus.O_txvalid) low_used++;
      bus.fe_txrdy = rdy;
      if (abort_at >= 0 && bus.O_txvalid && got.size() == abort_at) begin
        bus.I_abort = 1'b1;
        bus.I_start = 1'b1;
        bus.I_load_wr = 1'b1;
        bus.I_load_addr = 6'd0;
        bus.I_load_data = 8'hEE;
      end
      if (bus.O_txvalid && rdy) got.push_back(bus.O_fe_data);
      prev_hold = bus.O_txvalid && !rdy;
      prev_d = bus.O_fe_data;
      @(posedge clk); #1;
      bus.I_abort = 1'b0;
      bus.I_start = 1'b0;
      bus.I_load_wr = 1'b0;
    end
    bus.fe_txrdy = 1'b0;
    chk("done_seen", 32'(done_k >= 0), 1);
    @(posedge clk); #1;
    opm_after = bus.O_opmode;
    busy_after = bus.O_busy;
    oe_after = bus.O_fe_data_oe;
  endtask

  task automatic chk_pkt(input string tag, input int gap);
    chk({tag, "_len"}, got.size(), exp_q.size());
    chk({tag, "_bytes"}, mism(), 0);
    chk({tag, "_status"}, st, 2'b00);
    chk({tag, "_rise"}, rise, gap + 1);
    chk({tag, "_opm"}, 32'(opm_bad), 0);
  endtask

  initial begin
    int g, n;
    bit dseen;
    rst = 1'b1;
    bus.I_load_data = 8'h0; bus.I_load_addr = '0; bus.I_load_wr = 1'b0; bus.I_len = '0; bus.I_gap = '0;
    bus.I_start = 1'b0; bus.I_abort = 1'b0; bus.fe_txrdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_txvalid", bus.O_txvalid, 0);
    chk("rst_oe", bus.O_fe_data_oe, 0);
    chk("rst_data", bus.O_fe_data, 0);
    chk("rst_opmode", bus.O_opmode, 2'b01);
    chk("rst_busy", bus.O_busy, 0);
    chk("rst_done", bus.O_done, 0);
    chk("rst_status", bus.O_status, 0);
    chk("rst_load_err", bus.O_load_err, 0);
    rst = 1'b0;
    load(0, 8'hC3); load(1, 8'h11); load(2, 8'h22); load(3, 8'h33);
    // basic packet with ready held high
    start_pkt(4, 0);
    run_tx(0, -1, 8'h00);
    build_exp(4);
    chk_pkt("t1", 0);
    chk("t1_hi", hi, exp_q.size());
    chk("t1_done_k", done_k, exp_q.size() + 1);
    chk("t1_opm_first", opm_first, 2'b00);
    chk("t1_opm_after", opm_after, 2'b01);
    chk("t1_oe_after", oe_after, 0);
    chk("t1_busy_after", busy_after, 0);
    // ready stalls on byte 2
    start_pkt(4, 0);
    run_tx(3, -1, 8'h22);
    chk_pkt("t2", 0);
    chk("t2_hold", hold_cnt, 4);
    chk("t2_stable", 32'(stab_bad), 0);
    chk("t2_hi", hi, exp_q.size() + 3);
    // ready stuck low
    start_pkt(4, 0);
    run_tx(2, -1, 8'h00);
    chk("t3_hi", hi, 17);
    chk("t3_status", st, 2'b10);
    chk("t3_done_k", done_k, 18);
    chk("t3_bytes", got.size(), 0);
    chk("t3_opm_after", opm_after, 2'b01);
    // abort on byte 1 with a start and a load attempted while busy
    start_pkt(4, 0);
    run_tx(0, 1, 8'h00);
    chk("t4_status", st, 2'b01);
    chk("t4_load_err", bus.O_load_err, 1);
    chk("t4_busy_after", busy_after, 0);
    start_pkt(4, 0);
    run_tx(1, -1, 8'h00);
    build_exp(4);
    chk_pkt("t4b", 0);
    chk("t4b_load_err", bus.O_load_err, 0);
    // zero length
    start_pkt(0, 0);
    run_tx(0, -1, 8'h00);
    chk("t5_done_k", done_k, 0);
    chk("t5_hi", hi, 0);
    chk("t5_status", st, 2'b00);
    chk("t5_opm", opm_first, 2'b01);
    // oversize length clamps to the buffer depth
    for (int i = 0; i < 64; i++) load(i, 8'($urandom));
    g = $urandom_range(0, 5);
    start_pkt(80, g);
    run_tx(1, -1, 8'h00);
    build_exp(80);
    chk_pkt("t5_clamp", g);
    // reset in the middle of a packet
    start_pkt(20, 0);
    bus.fe_txrdy = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_rst_txvalid", bus.O_txvalid, 0);
    chk("t5_rst_opmode", bus.O_opmode, 2'b01);
    chk("t5_rst_oe", bus.O_fe_data_oe, 0);
    chk("t5_rst_busy", bus.O_busy, 0);
    dseen = 0;
    repeat (4) begin
      if (bus.O_done) dseen = 1;
      @(posedge clk); #1;
    end
    chk("t5_rst_no_done", 32'(dseen), 0);
    bus.fe_txrdy = 1'b0;
    // PID only, then PID plus a short payload
    load(0, 8'hC3);
    start_pkt(1, 0);
    run_tx(0, -1, 8'h00);
    build_exp(1);
    chk_pkt("t6_pid", 0);
    load(1, 8'h00); load(2, 8'h01); load(3, 8'h02); load(4, 8'h03);
    start_pkt(5, 2);
    run_tx(1, -1, 8'h00);
    build_exp(5);
    chk_pkt("t6_data", 2);
    // random packets
    repeat (4) begin
      n = $urandom_range(1, 64);
      g = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) load(i, 8'($urandom));
      start_pkt(n, g);
      run_tx(1, -1, 8'h00);
      build_exp(n);
      chk_pkt("rnd", g);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
